out_byte_uart_tx: RTL

- Consumer (reader) end of the SoC's out_byte/out_byte_en debug byte stream, which the CPU produces by storing to 0x1000_0000.
- The producer pulses out_byte_en for one cycle per byte and has no backpressure, so this block buffers bytes in a FIFO.
- Each byte is serialised as 8N1 UART on a Tang Nano 20K pin, which gives the board a console.

---
 rtl/out_byte_uart_tx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/out_byte_uart_tx.sv
// Buffers the CPU's out_byte/out_byte_en debug stream in a byte FIFO and sends it as an 8N1 UART line.
// Define OUT_BYTE_UART_TX_PARITY_EN to append an even-parity bit (8E1) between bit7 and the stop bit.
module out_byte_uart_tx #(
  parameter int CLK_HZ     = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] out_byte,
  input  logic       out_byte_en,
  output logic       uart_tx,
  output logic       busy,
  output logic       fifo_full,
  output logic       overflow
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("out_byte_uart_tx: CLK_HZ/BAUD gives DIV < 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef OUT_BYTE_UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
`ifdef OUT_BYTE_UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic        empty, full, pop, push;
  logic [7:0]  head;

  // Producer side is valid-only: out_byte is taken on any edge with out_byte_en=1 and there is
  // no ready; a strobe into a full FIFO is accepted only if the FSM pops in that same cycle.
  always_comb begin
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop        = (state == IDLE) && !empty;
    push       = out_byte_en && (!full || pop);
    wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
    rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    head       = mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= out_byte;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
`ifdef OUT_BYTE_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      fifo_full <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                   (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      if (out_byte_en && full && !pop) overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= head;
            uart_tx <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= START;
`ifdef OUT_BYTE_UART_TX_PARITY_EN
            parity_bit <= ^head;
`endif
          end else begin
            busy <= 1'b0;
          end
        end
        START: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            uart_tx <= shreg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef OUT_BYTE_UART_TX_PARITY_EN
              uart_tx <= parity_bit;
              state   <= PARITY;
`else
              uart_tx <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              shreg   <= {1'b0, shreg[7:1]};
              uart_tx <= shreg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef OUT_BYTE_UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            uart_tx <= 1'b1;
            state   <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            // Stay busy across the idle cycle only if another byte is already waiting.
            busy  <= !empty;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
